// File: rtl/redutor_bit.sv
//------------------------------------------------------------------------------
//  Module      : redutor_bit
//  Description : Packs a 32-bit signed value into a 16-bit I-type immediate
//                (sel=0) or a 26-bit J-type target (sel=1). It flags values
//                that do not fit and counts them in a saturating counter.
//                Results are held in a 2-entry FIFO with a valid/ready
//                handshake on both sides.
//  Options     : REDUTOR_SATURA_EN - clamp out-of-range values to the field
//                extremes instead of truncating them.
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module redutor_bit #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel,
    input  logic [31:0]      entrada,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [25:0]      saida,
    output logic             sel_out,
    output logic             overflow,
    output logic [CNT_W-1:0] ovf_count
);

    // Buffer occupancy states
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Entry layout: {sel, overflow, field[25:0]}
    logic [1:0]       r_state;
    logic [27:0]      r_head;
    logic [27:0]      r_tail;
    logic [CNT_W-1:0] r_ovf_count;

    logic             w_push;
    logic             w_pop;
    logic             w_in_range;
    logic [25:0]      w_field;
    logic [27:0]      w_entry;

    assign in_ready  = (r_state != c_ST_FULL);
    assign out_valid = (r_state != c_ST_EMPTY);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // A value fits when every bit above the field's sign bit copies it
    assign w_in_range = sel ? ((&entrada[31:25]) | ~(|entrada[31:25]))
                            : ((&entrada[31:15]) | ~(|entrada[31:15]));

    // Field value: low bits of the input, or a clamp when saturation is built in
    always_comb begin
        w_field = sel ? entrada[25:0] : {10'b0, entrada[15:0]};
`ifdef REDUTOR_SATURA_EN
        if (!w_in_range) begin
            if (sel)
                w_field = entrada[31] ? 26'h2000000 : 26'h1FFFFFF;
            else
                w_field = entrada[31] ? 26'h0008000 : 26'h0007FFF;
        end
`else
        w_field = w_field;
`endif
    end

    assign w_entry = {sel, ~w_in_range, w_field};

    // FIFO state and storage; the head register always drives the outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_push) begin
                        r_head  <= w_entry;
                        r_state <= c_ST_ONE;
                    end
                end
                c_ST_ONE: begin
                    if (w_push && w_pop) begin
                        r_head <= w_entry;
                    end else if (w_push) begin
                        r_tail  <= w_entry;
                        r_state <= c_ST_FULL;
                    end else if (w_pop) begin
                        r_state <= c_ST_EMPTY;
                    end
                end
                c_ST_FULL: begin
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_state <= c_ST_ONE;
                    end
                end
                default: r_state <= c_ST_EMPTY;
            endcase
        end
    end

    // Overflow events are counted when accepted, saturating at all-ones
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovf_count <= '0;
        end else if (w_push && !w_in_range && (r_ovf_count != c_CNT_MAX)) begin
            r_ovf_count <= r_ovf_count + c_CNT_ONE;
        end
    end

    assign saida     = r_head[25:0];
    assign overflow  = r_head[26];
    assign sel_out   = r_head[27];
    assign ovf_count = r_ovf_count;

endmodule

`default_nettype wire

// File: tb/tb_redutor_bit.sv
//------------------------------------------------------------------------------
//  Module      : tb_redutor_bit
//  Description : Directed self-checking bench for redutor_bit.
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_redutor_bit;

    localparam int CNT_W = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             sel;
    logic [31:0]      entrada;
    logic             out_valid;
    logic             out_ready;
    logic [25:0]      saida;
    logic             sel_out;
    logic             overflow;
    logic [CNT_W-1:0] ovf_count;

    int n_total = 0;
    int n_pass  = 0;
    int exp_cnt = 0;

    redutor_bit #(.CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .entrada   (entrada),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .saida     (saida),
        .sel_out   (sel_out),
        .overflow  (overflow),
        .ovf_count (ovf_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle 1 time unit past it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic        s;
        logic [31:0] v;
        logic [25:0] trunc;
        logic [25:0] sat;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 32'hFFFF8000, 26'h0008000, 26'h0008000, 1'b0};
        vecs[1] = '{1'b0, 32'h00007FFF, 26'h0007FFF, 26'h0007FFF, 1'b0};
        vecs[2] = '{1'b0, 32'h00008000, 26'h0008000, 26'h0007FFF, 1'b1};
        vecs[3] = '{1'b1, 32'hFE000000, 26'h2000000, 26'h2000000, 1'b0};
        vecs[4] = '{1'b1, 32'h02000000, 26'h2000000, 26'h1FFFFFF, 1'b1};
        vecs[5] = '{1'b0, 32'hFFFF7FFF, 26'h0007FFF, 26'h0008000, 1'b1};
        vecs[6] = '{1'b1, 32'h01FFFFFF, 26'h1FFFFFF, 26'h1FFFFFF, 1'b0};
        vecs[7] = '{1'b0, 32'h12345678, 26'h0005678, 26'h0007FFF, 1'b1};

        reset = 1'b0; in_valid = 1'b0; sel = 1'b0; entrada = '0; out_ready = 1'b0;
        do_reset();

        // Reset state
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_saida",     {6'b0, saida},      32'd0);
        chk("rst_sel_out",   {31'b0, sel_out},   32'd0);
        chk("rst_overflow",  {31'b0, overflow},  32'd0);
        chk("rst_ovf_count", {24'b0, ovf_count}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);

        // Packing and range check, one value at a time through an empty buffer
        for (int i = 0; i < 8; i++) begin
            sel = vecs[i].s; entrada = vecs[i].v; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            if (vecs[i].ovf) exp_cnt++;
            chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'd1);
`ifdef REDUTOR_SATURA_EN
            chk($sformatf("v%0d_saida", i), {6'b0, saida}, {6'b0, vecs[i].sat});
`else
            chk($sformatf("v%0d_saida", i), {6'b0, saida}, {6'b0, vecs[i].trunc});
`endif
            chk($sformatf("v%0d_ovf", i),   {31'b0, overflow}, {31'b0, vecs[i].ovf});
            chk($sformatf("v%0d_sel", i),   {31'b0, sel_out},  {31'b0, vecs[i].s});
            chk($sformatf("v%0d_cnt", i),   {24'b0, ovf_count}, exp_cnt);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("v%0d_drain", i), {31'b0, out_valid}, 32'd0);
        end

        // Empty-buffer pop has no effect
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("empty_pop_valid", {31'b0, out_valid}, 32'd0);
        chk("empty_pop_ready", {31'b0, in_ready},  32'd1);

        // FIFO ordering, backpressure and simultaneous push/pop
        sel = 1'b0; in_valid = 1'b1; entrada = 32'h1;
        tick();
        chk("fifo_A_ready", {31'b0, in_ready}, 32'd1);
        entrada = 32'h2;
        tick();
        chk("fifo_full_ready", {31'b0, in_ready}, 32'd0);
        chk("fifo_head_A",     {6'b0, saida},     32'h1);
        entrada = 32'h3;
        tick();
        chk("fifo_hold_ready", {31'b0, in_ready}, 32'd0);
        chk("fifo_hold_A",     {6'b0, saida},     32'h1);
        out_ready = 1'b1;
        tick();
        chk("fifo_head_B",     {6'b0, saida},     32'h2);
        chk("fifo_ready_one",  {31'b0, in_ready}, 32'd1);
        tick();
        chk("fifo_head_C",     {6'b0, saida},     32'h3);
        chk("fifo_pp_valid",   {31'b0, out_valid}, 32'd1);
        chk("fifo_pp_ready",   {31'b0, in_ready}, 32'd1);
        in_valid = 1'b0;
        tick();
        chk("fifo_drained",    {31'b0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Saturating overflow counter
        do_reset();
        chk("sat_cnt_cleared", {24'b0, ovf_count}, 32'd0);
        sel = 1'b1; entrada = 32'h40000000; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 254) chk("sat_cnt_254", {24'b0, ovf_count}, 32'd254);
            if (i == 255) chk("sat_cnt_255", {24'b0, ovf_count}, 32'd255);
        end
        chk("sat_cnt_300", {24'b0, ovf_count}, 32'd255);
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;

        // Reset while full, with an overflowing input presented
        do_reset();
        sel = 1'b0; entrada = 32'h00008000; in_valid = 1'b1;
        tick();
        tick();
        chk("pre_rst_full", {31'b0, in_ready},  32'd0);
        chk("pre_rst_cnt",  {24'b0, ovf_count}, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_cnt",   {24'b0, ovf_count}, 32'd0);
        chk("mid_rst_ready", {31'b0, in_ready},  32'd1);
        chk("mid_rst_saida", {6'b0, saida},      32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
